// File: rtl/sqrt_launch_ctrl.sv
// sqrt_launch_ctrl: data-memory sequencer for an 8-bit integer square root; define SQRT_ROUND_EN for round-to-nearest
module sqrt_launch_ctrl #(
  parameter int AW = 8,
  parameter logic [AW-1:0] OPERAND_ADDR = AW'(16),
  parameter logic [AW-1:0] RESULT_ADDR = AW'(18)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_ack,
  output logic          o_busy,
  input  logic [AW-1:0] i_core_addr,
  input  logic          i_core_read_mem,
  input  logic          i_core_write_mem,
  input  logic [7:0]    i_core_data_in,
  output logic          o_core_stall,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_read_mem,
  output logic          o_mem_write_mem,
  output logic [7:0]    o_mem_data_in,
  input  logic [7:0]    i_mem_data_out
);
`ifdef SQRT_ROUND_EN
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, ITER, ROUND, WR, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, ITER, WR, DONE} state_t;
`endif
  state_t r_state, w_next;
  logic r_start_q;
  logic [15:0] r_op;
  logic [7:0] r_root;
  logic [10:0] r_rem;
  logic [2:0] r_cnt;
  logic w_launch, w_busy, w_ge;
  logic [10:0] w_rem_sh, w_trial;
  assign w_busy = !(r_state == IDLE || r_state == DONE);
  assign w_launch = i_start && !r_start_q && !w_busy;
  assign w_rem_sh = 11'({r_rem, r_op[15:14]});
  assign w_trial = {1'b0, r_root, 2'b01};
  assign w_ge = w_rem_sh >= w_trial;
  assign o_busy = w_busy;
  assign o_core_stall = w_busy;
  assign o_ack = r_state == DONE;
  assign o_mem_addr = !w_busy ? i_core_addr :
                      r_state == RD_HI ? OPERAND_ADDR :
                      r_state == RD_LO ? OPERAND_ADDR + AW'(1) : RESULT_ADDR;
  assign o_mem_read_mem = w_busy ? (r_state == RD_HI || r_state == RD_LO) : i_core_read_mem;
  // a reset landing in WR must not let the abandoned result reach memory
  assign o_mem_write_mem = w_busy ? (r_state == WR && !i_reset) : i_core_write_mem;
  assign o_mem_data_in = w_busy ? r_root : i_core_data_in;
  // state register
  always_ff @(posedge i_clk) begin
    r_state <= i_reset ? IDLE : w_next;
  end
  // next-state sequencing: two reads, eight digit iterations, optional rounding, one write
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_launch ? RD_HI : r_state;
      RD_HI: w_next = RD_LO;
      RD_LO: w_next = ITER;
`ifdef SQRT_ROUND_EN
      ITER: w_next = r_cnt == 3'd7 ? ROUND : ITER;
      ROUND: w_next = WR;
`else
      ITER: w_next = r_cnt == 3'd7 ? WR : ITER;
`endif
      WR: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // operand capture and restoring square-root datapath, MSB digit pair first
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_start_q <= 1'b0;
      r_op <= '0;
      r_root <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else begin
      r_start_q <= i_start;
      case (r_state)
        RD_HI: r_op[15:8] <= i_mem_data_out;
        RD_LO: begin
          r_op[7:0] <= i_mem_data_out;
          r_root <= '0;
          r_rem <= '0;
          r_cnt <= '0;
        end
        ITER: begin
          r_rem <= w_ge ? w_rem_sh - w_trial : w_rem_sh;
          r_root <= {r_root[6:0], w_ge};
          r_op <= {r_op[13:0], 2'b00};
          r_cnt <= r_cnt + 3'd1;
        end
`ifdef SQRT_ROUND_EN
        ROUND: r_root <= (r_rem > {3'b000, r_root} && r_root != 8'hff) ? r_root + 8'd1 : r_root;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_launch_ctrl.sv
// tb_sqrt_launch_ctrl: directed bench for sqrt_launch_ctrl with a byte-wide data memory model
module tb_sqrt_launch_ctrl;
  logic clk = 1'b0;
  logic reset, start, core_read, core_write;
  logic [7:0] core_addr, core_data;
  logic ack, busy, stall, mem_read, mem_write;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic [7:0] mem [256];
  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
`ifdef SQRT_ROUND_EN
  localparam int LAT = 13;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 12;
  localparam bit RND = 1'b0;
`endif
  sqrt_launch_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .o_ack(ack), .o_busy(busy),
    .i_core_addr(core_addr), .i_core_read_mem(core_read), .i_core_write_mem(core_write),
    .i_core_data_in(core_data), .o_core_stall(stall), .o_mem_addr(mem_addr),
    .o_mem_read_mem(mem_read), .o_mem_write_mem(mem_write), .o_mem_data_in(mem_din),
    .i_mem_data_out(mem_dout)
  );
  always #5 clk = ~clk;
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] = mem_din;
    if (mem_write && mem_addr == 8'd18) wr_cnt++;
    if (mem_read && busy) rd_cnt++;
  end
  task automatic launch(input logic [15:0] op);
    mem[16] = op[15:8];
    mem[17] = op[7:0];
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_ack(output int lat);
    lat = 1;
    while (!ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    core_addr = 8'd5;
    core_read = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL reset_rd_pass got=%b exp=1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_wr_pass got=%b exp=0", mem_write); end
    checks++; if (mem_addr !== 8'd5) begin errors++; $display("FAIL reset_addr_pass got=%0d exp=5", mem_addr); end
    reset = 1'b0;
    core_read = 1'b0;
    core_addr = 8'd0;
    @(negedge clk);
  endtask
  task automatic test_max;
    int lat, w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    mem[18] = 8'h00;
    launch(16'hFE01);
    wait_ack(lat);
    start = 1'b0;
    checks++; if (mem[18] !== 8'hFF) begin errors++; $display("FAIL max_result got=%h exp=ff", mem[18]); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL max_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL max_writes got=%0d exp=1", wr_cnt - w0); end
    checks++; if (rd_cnt - r0 !== 2) begin errors++; $display("FAIL max_reads got=%0d exp=2", rd_cnt - r0); end
  endtask
  task automatic test_values;
    logic [15:0] ops [7] = '{16'd0, 16'd16, 16'd24, 16'd65535, 16'd2, 16'd8, 16'd99};
    logic [7:0] flr [7] = '{8'd0, 8'd4, 8'd4, 8'd255, 8'd1, 8'd2, 8'd9};
    logic [7:0] rnd [7] = '{8'd0, 8'd4, 8'd5, 8'd255, 8'd1, 8'd3, 8'd10};
    int lat;
    logic [7:0] exp_v;
    for (int i = 0; i < 7; i++) begin
      mem[18] = 8'h5A;
      launch(ops[i]);
      wait_ack(lat);
      start = 1'b0;
      exp_v = RND ? rnd[i] : flr[i];
      checks++; if (mem[18] !== exp_v) begin errors++; $display("FAIL value_op%0d got=%h exp=%h", ops[i], mem[18], exp_v); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL value_lat_op%0d got=%0d exp=%0d", ops[i], lat, LAT); end
    end
  endtask
  task automatic test_stall;
    int lat;
    mem[40] = 8'h00;
    launch(16'd24);
    core_addr = 8'd40;
    core_data = 8'h77;
    core_write = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_flag got=%b exp=1", stall); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL stall_wr_blocked got=%b exp=0", mem_write); end
    checks++; if (mem_addr !== 8'd16) begin errors++; $display("FAIL stall_addr got=%0d exp=16", mem_addr); end
    wait_ack(lat);
    start = 1'b0;
    checks++; if (mem[40] !== 8'h00) begin errors++; $display("FAIL stall_no_core_write got=%h exp=00", mem[40]); end
    checks++; if (mem[18] !== (RND ? 8'd5 : 8'd4)) begin errors++; $display("FAIL stall_result got=%h exp=%h", mem[18], RND ? 8'd5 : 8'd4); end
    checks++; if (mem_write !== 1'b1 || mem_addr !== 8'd40) begin errors++; $display("FAIL stall_pass got=%b/%0d exp=1/40", mem_write, mem_addr); end
    @(negedge clk);
    core_write = 1'b0;
    checks++; if (mem[40] !== 8'h77) begin errors++; $display("FAIL stall_core_landed got=%h exp=77", mem[40]); end
  endtask
  task automatic test_reset_mid;
    int lat, w0;
    mem[18] = 8'hAA;
    w0 = wr_cnt;
    launch(16'hFE01);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack got=%b exp=0", ack); end
    repeat (15) @(negedge clk);
    checks++; if (mem[18] !== 8'hAA) begin errors++; $display("FAIL abort_mem got=%h exp=aa", mem[18]); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL abort_writes got=%0d exp=%0d", wr_cnt, w0); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack_late got=%b exp=0", ack); end
    launch(16'd16);
    wait_ack(lat);
    start = 1'b0;
    checks++; if (mem[18] !== 8'd4) begin errors++; $display("FAIL abort_rerun got=%h exp=04", mem[18]); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_rerun_lat got=%0d exp=%0d", lat, LAT); end
  endtask
  task automatic test_back_to_back;
    int lat, w0;
    launch(16'd65535);
    wait_ack(lat);
    w0 = wr_cnt;
    mem[16] = 8'h00;
    mem[17] = 8'd99;
    repeat (20) @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL hold_ack got=%b exp=1", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy got=%b exp=0", busy); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL hold_writes got=%0d exp=%0d", wr_cnt, w0); end
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL relaunch_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL relaunch_busy got=%b exp=1", busy); end
    wait_ack(lat);
    start = 1'b0;
    checks++; if (mem[18] !== (RND ? 8'd10 : 8'd9)) begin errors++; $display("FAIL relaunch_result got=%h exp=%h", mem[18], RND ? 8'd10 : 8'd9); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL relaunch_lat got=%0d exp=%0d", lat, LAT); end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    core_read = 1'b0;
    core_write = 1'b0;
    core_addr = 8'd0;
    core_data = 8'd0;
    test_reset;
    test_max;
    test_values;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
